// File: rtl/lcd_char_receiver.sv
// lcd_char_receiver: passive listener on an HD44780-style 8-bit LCD write bus.
// Mirrors the controller's 2x16 character cells, cursor (DDRAM address) and
// display mode bits so the host can read back what the LCD is showing.
// Optional feature: define LCD_RX_INIT_CHECK_EN to require a valid function
// set (D[4]=1, D[3]=1) before any other transaction is accepted.
module lcd_char_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DATA,
    input  logic [4:0] RD_ADDR,
    input  logic       ERR_CLR,
    output logic [7:0] RD_DATA,
    output logic [6:0] CURSOR,
    output logic       DISP_ON,
    output logic       CURSOR_ON,
    output logic       BLINK_ON,
    output logic       INC_MODE,
    output logic       BUSY,
    output logic       WR_STROBE,
    output logic       PROTO_ERR
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    // Bus word layout: {E, RS, RW, DATA[7:0]}
    localparam int         BW        = 11;
    localparam logic [2:0] SUPP_LAST = 3'(SYNC_STAGES + 1);
    localparam logic [7:0] BLANK     = 8'h20;

    logic [BW-1:0] sync_q [SYNC_STAGES];
    logic [BW-1:0] sync_d [SYNC_STAGES];
    logic [BW-1:0] bus_s;
    logic [BW-1:0] prev_q, prev_d;
    logic [2:0]    supp_q, supp_d;
    logic          edge_det;
    logic          pend_q, pend_d;
    logic [9:0]    pend_bus_q, pend_bus_d;

    state_t        state_q, state_d;
    logic [4:0]    clr_idx_q, clr_idx_d;
    logic [6:0]    cursor_q, cursor_d;
    logic          disp_q, disp_d;
    logic          curs_on_q, curs_on_d;
    logic          blink_q, blink_d;
    logic          inc_q, inc_d;
    logic          err_q, err_d;
    logic          strobe_q, strobe_d;
    logic [7:0]    rd_data_q, rd_data_d;

    logic [7:0]    cell_q [32];
    logic [7:0]    cell_d [32];
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [7:0]    wr_data;
    logic          new_err;
    logic          init_blk;

`ifdef LCD_RX_INIT_CHECK_EN
    logic          init_q, init_d;
`endif

    logic          pend_rs, pend_rw;
    logic [7:0]    pend_dat;

    assign pend_rs  = pend_bus_q[9];
    assign pend_rw  = pend_bus_q[8];
    assign pend_dat = pend_bus_q[7:0];
    assign bus_s    = sync_q[SYNC_STAGES-1];

    // Next cursor value after a data write, with the two-line wrap points
    function automatic logic [6:0] cursor_step(input logic [6:0] c, input logic up);
        logic [6:0] r;
        if (up) begin
            if (c == 7'h27)      r = 7'h40;
            else if (c == 7'h67) r = 7'h00;
            else                 r = c + 7'd1;
        end else begin
            if (c == 7'h00)      r = 7'h67;
            else if (c == 7'h40) r = 7'h27;
            else                 r = c - 7'd1;
        end
        return r;
    endfunction

    // Synchronizer shift chain, edge detector and one-cycle transaction latch
    always_comb begin
        sync_d[0] = {LCD_E, LCD_RS, LCD_RW, LCD_DATA};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d     = bus_s;
        supp_d     = (supp_q == SUPP_LAST) ? supp_q : supp_q + 3'd1;
        // prev_q holds the last cycle E was high, so its RS/RW/DATA are latched
        edge_det   = (supp_q == SUPP_LAST) && prev_q[10] && !bus_s[10];
        pend_d     = edge_det;
        pend_bus_d = edge_det ? prev_q[9:0] : pend_bus_q;
    end

    // Command decode, data write, clear sequencer and error tracking
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        cursor_d  = cursor_q;
        disp_d    = disp_q;
        curs_on_d = curs_on_q;
        blink_d   = blink_q;
        inc_d     = inc_q;
        err_d     = err_q;
        strobe_d  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 5'd0;
        wr_data   = 8'h00;
        new_err   = 1'b0;
        init_blk  = 1'b0;
`ifdef LCD_RX_INIT_CHECK_EN
        init_d    = init_q;
        init_blk  = !init_q && !(!pend_rs && !pend_rw && pend_dat[7:5] == 3'b001);
`endif
        if (state_q == ST_CLEAR) begin
            wr_en     = 1'b1;
            wr_addr   = clr_idx_q;
            wr_data   = BLANK;
            clr_idx_d = clr_idx_q + 5'd1;
            if (clr_idx_q == 5'd31) begin
                state_d  = ST_IDLE;
                cursor_d = 7'h00;
                inc_d    = 1'b1;
            end
        end
        if (pend_q) begin
            if (state_q == ST_CLEAR || init_blk) begin
                new_err = 1'b1;
            end else if (!pend_rw) begin
                strobe_d = 1'b1;
                if (pend_rs) begin
                    // Only the visible 16 columns of each line are mirrored
                    if (cursor_q[6:4] == 3'b000) begin
                        wr_en   = 1'b1;
                        wr_addr = {1'b0, cursor_q[3:0]};
                        wr_data = pend_dat;
                    end else if (cursor_q[6:4] == 3'b100) begin
                        wr_en   = 1'b1;
                        wr_addr = {1'b1, cursor_q[3:0]};
                        wr_data = pend_dat;
                    end
                    cursor_d = cursor_step(cursor_q, inc_q);
                end else begin
                    casez (pend_dat)
                        8'b1???????: begin
                            if ((pend_dat[6:0] >= 7'h28 && pend_dat[6:0] <= 7'h3F) ||
                                pend_dat[6:0] >= 7'h68) begin
                                cursor_d = 7'h00;
                                new_err  = 1'b1;
                            end else begin
                                cursor_d = pend_dat[6:0];
                            end
                        end
                        8'b01??????: begin end
                        8'b001?????: begin
`ifdef LCD_RX_INIT_CHECK_EN
                            if (pend_dat[4] && pend_dat[3]) init_d = 1'b1;
`endif
                        end
                        8'b0001????: begin end
                        8'b00001???: begin
                            disp_d    = pend_dat[2];
                            curs_on_d = pend_dat[1];
                            blink_d   = pend_dat[0];
                        end
                        8'b000001??: inc_d = pend_dat[1];
                        8'b0000001?: cursor_d = 7'h00;
                        8'b00000001: begin
                            state_d   = ST_CLEAR;
                            clr_idx_d = 5'd0;
                        end
                        default: begin end
                    endcase
                end
            end
        end
        // A fresh error wins over a simultaneous clear request
        if (ERR_CLR) err_d = 1'b0;
        if (new_err) err_d = 1'b1;
    end

    // Single write port into the character cells, registered read
    always_comb begin
        cell_d = cell_q;
        if (wr_en) cell_d[wr_addr] = wr_data;
        rd_data_d = cell_q[RD_ADDR];
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int i = 0; i < 32; i++) cell_q[i] <= BLANK;
            prev_q     <= '0;
            supp_q     <= 3'd0;
            pend_q     <= 1'b0;
            pend_bus_q <= '0;
            state_q    <= ST_IDLE;
            clr_idx_q  <= 5'd0;
            cursor_q   <= 7'h00;
            disp_q     <= 1'b0;
            curs_on_q  <= 1'b0;
            blink_q    <= 1'b0;
            inc_q      <= 1'b1;
            err_q      <= 1'b0;
            strobe_q   <= 1'b0;
            rd_data_q  <= 8'h00;
`ifdef LCD_RX_INIT_CHECK_EN
            init_q     <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            for (int i = 0; i < 32; i++) cell_q[i] <= cell_d[i];
            prev_q     <= prev_d;
            supp_q     <= supp_d;
            pend_q     <= pend_d;
            pend_bus_q <= pend_bus_d;
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            cursor_q   <= cursor_d;
            disp_q     <= disp_d;
            curs_on_q  <= curs_on_d;
            blink_q    <= blink_d;
            inc_q      <= inc_d;
            err_q      <= err_d;
            strobe_q   <= strobe_d;
            rd_data_q  <= rd_data_d;
`ifdef LCD_RX_INIT_CHECK_EN
            init_q     <= init_d;
`endif
        end
    end

    assign RD_DATA   = rd_data_q;
    assign CURSOR    = cursor_q;
    assign DISP_ON   = disp_q;
    assign CURSOR_ON = curs_on_q;
    assign BLINK_ON  = blink_q;
    assign INC_MODE  = inc_q;
    assign BUSY      = (state_q == ST_CLEAR);
    assign WR_STROBE = strobe_q;
    assign PROTO_ERR = err_q;

endmodule
